bmp_stream_loader: RTL

- Sits between data_io's ioctl byte stream and the SRAM port arbiter of the menu core.
- Parses the BMP header on the fly: signature, pixel-data offset, width, height and bpp.
- Validates the header, then converts each pixel-data byte into an SRAM write request {addr, data}.
- Requests are buffered in a small FIFO and drained through a valid/ready handshake, so the arbiter can interleave video fetches without losing bytes.

---
 rtl/bmp_stream_loader.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/bmp_stream_loader.sv
// Parses a 32bpp BMP header from the ioctl byte stream and turns the pixel
// bytes into SRAM write requests, buffered in a small valid/ready FIFO.
module bmp_stream_loader #(
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_BYTES  = 524288,
  parameter int MAX_WIDTH  = 512,
  parameter int MAX_HEIGHT = 312
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [18:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [9:0]  bmp_width,
  output logic [8:0]  bmp_height,
  output logic        bmp_loaded,
  output logic        bmp_error,
  output logic        fifo_overflow
);
  // state  | meaning
  // IDLE   | no download seen since reset
  // HEADER | capturing header fields from bytes 0..29
  // PIXELS | pushing pixel bytes into the FIFO
  // DRAIN  | download ended, emptying the FIFO
  // DONE   | image fully written, bmp_loaded=1
  // ERROR  | header rejected or file truncated, bmp_error=1
  typedef enum logic [2:0] {IDLE, HEADER, PIXELS, DRAIN, DONE, ERROR} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]  PTR_ONE      = (AW+1)'(1);
  localparam logic [31:0]  MAX_BYTES_W  = 32'(MAX_BYTES);
  localparam logic [15:0]  MAX_WIDTH_W  = 16'(MAX_WIDTH);
  localparam logic [15:0]  MAX_HEIGHT_W = 16'(MAX_HEIGHT);

  state_t      state, state_nxt;
  logic        wr_q, dl_q, byte_ev, dl_rise;
  logic [7:0]  sig0, sig1, bpp_lo;
  logic [31:0] data_start;
  logic [15:0] width, height;
  logic        size_hi_bad, hdr_ok;
  logic        start, flush, set_error, set_loaded, stage_push;
  logic [31:0] addr_ext;
  logic [23:0] pix_idx;
  logic        push_v;
  logic [18:0] push_addr;
  logic [7:0]  push_data;
  logic [AW:0] wptr, rptr;
  logic [26:0] mem [FIFO_DEPTH];
  logic        fifo_empty, fifo_full, pop, do_push;

  // dl_q resets high so a download already in progress is not seen as a new one
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_q <= 1'b0;
      dl_q <= 1'b1;
    end else begin
      wr_q <= ioctl_wr;
      dl_q <= ioctl_download;
    end
  end

  assign byte_ev  = ioctl_wr & ~wr_q;
  assign dl_rise  = ioctl_download & ~dl_q;
  assign addr_ext = {7'd0, ioctl_addr};
  assign pix_idx  = 24'(addr_ext - data_start);

  // bpp high byte is checked live, as it arrives with the validating event
  assign hdr_ok = (sig0 == 8'h42) && (sig1 == 8'h4D)
               && ({ioctl_dout, bpp_lo} == 16'd32)
               && (width != 16'd0) && (width <= MAX_WIDTH_W)
               && (height != 16'd0) && (height <= MAX_HEIGHT_W)
               && !size_hi_bad
               && (data_start >= 32'd30) && (data_start[31:24] == 8'd0);

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERROR: if (dl_rise) state_nxt = HEADER;
      HEADER: begin
        if (!ioctl_download)
          state_nxt = ERROR;
        else if (byte_ev && ioctl_addr == 25'd29)
          state_nxt = hdr_ok ? PIXELS : ERROR;
      end
      PIXELS: if (!ioctl_download) state_nxt = DRAIN;
      DRAIN:  if (fifo_empty && !push_v) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start      = 1'b0;
    set_error  = 1'b0;
    set_loaded = 1'b0;
    stage_push = 1'b0;
    case (state)
      IDLE, DONE, ERROR: start = dl_rise;
      HEADER: set_error = (state_nxt == ERROR);
      PIXELS: stage_push = byte_ev && (addr_ext >= data_start)
                        && ({8'd0, pix_idx} < MAX_BYTES_W);
      DRAIN:  set_loaded = (state_nxt == DONE);
      default: ;
    endcase
    flush = start | set_error;
  end

  always_ff @(posedge clk_sys) begin
    if (reset || start) begin
      sig0        <= 8'd0;
      sig1        <= 8'd0;
      bpp_lo      <= 8'd0;
      data_start  <= 32'd0;
      width       <= 16'd0;
      height      <= 16'd0;
      size_hi_bad <= 1'b0;
    end else if (state == HEADER && byte_ev) begin
      case (ioctl_addr)
        25'd0:  sig0              <= ioctl_dout;
        25'd1:  sig1              <= ioctl_dout;
        25'd10: data_start[7:0]   <= ioctl_dout;
        25'd11: data_start[15:8]  <= ioctl_dout;
        25'd12: data_start[23:16] <= ioctl_dout;
        25'd13: data_start[31:24] <= ioctl_dout;
        25'd18: width[7:0]        <= ioctl_dout;
        25'd19: width[15:8]       <= ioctl_dout;
        25'd22: height[7:0]       <= ioctl_dout;
        25'd23: height[15:8]      <= ioctl_dout;
        25'd20, 25'd21, 25'd24, 25'd25:
          if (ioctl_dout != 8'd0) size_hi_bad <= 1'b1;
        25'd28: bpp_lo            <= ioctl_dout;
        default: ;
      endcase
    end
  end

  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop        = wr_valid && wr_ready;
  assign do_push    = push_v && (!fifo_full || pop);

  always_ff @(posedge clk_sys) begin
    if (reset || flush) begin
      push_v    <= 1'b0;
      push_addr <= 19'd0;
      push_data <= 8'd0;
      wptr      <= '0;
      rptr      <= '0;
    end else begin
      push_v    <= stage_push;
      push_addr <= pix_idx[18:0];
      push_data <= ioctl_dout;
      if (do_push) wptr <= wptr + PTR_ONE;
      if (pop)     rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wptr[AW-1:0]] <= {push_addr, push_data};
  end

  always_ff @(posedge clk_sys) begin
    if (reset || start) begin
      bmp_loaded    <= 1'b0;
      bmp_error     <= 1'b0;
      fifo_overflow <= 1'b0;
    end else begin
      if (set_error)  bmp_error  <= 1'b1;
      if (set_loaded) bmp_loaded <= 1'b1;
      if (push_v && fifo_full && !pop) fifo_overflow <= 1'b1;
    end
  end

  assign wr_valid           = !fifo_empty;
  assign {wr_addr, wr_data} = wr_valid ? mem[rptr[AW-1:0]] : 27'd0;
  assign bmp_width          = width[9:0];
  assign bmp_height         = height[8:0];

endmodule
